// File: rtl/mips_pkg.sv
// Shared types and helpers for the branch target buffer: FSM encoding,
// index/tag width derivation and the weakly-taken counter value.
package mips_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } btb_state_e;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Word-aligned PCs: bits [1:0] are neither index nor tag.
    function automatic int tag_w(input int addr_w, input int entries);
        return addr_w - $clog2(entries) - 2;
    endfunction

    function automatic logic [31:0] weak_taken(input int ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/mips_sat_ctr.sv
// Combinational saturating up/down counter step used for branch direction training.
module mips_sat_ctr #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != '1) ctr_o = ctr_i + 1'b1;
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
        end
    end

endmodule

// File: rtl/mips_btb.sv
// Direct-mapped branch target buffer with zero-latency lookup, EX-stage training
// and a one-entry-per-cycle flush walk.
module mips_btb
    import mips_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int ADDR_W    = 32,
    parameter int CTR_W     = 2,
    parameter int PRED_MODE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush,
    output logic              busy
);

    localparam int                IDX_W  = idx_w(ENTRIES);
    localparam int                TAG_W  = tag_w(ADDR_W, ENTRIES);
    localparam logic [31:0]       WT32   = weak_taken(CTR_W);
    localparam logic [CTR_W-1:0]  CTR_WT = WT32[CTR_W-1:0];
    localparam logic [IDX_W-1:0]  LAST   = IDX_W'(ENTRIES - 1);

    btb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [ENTRIES];
    logic [TAG_W-1:0]  tag_d [ENTRIES];
    logic [ADDR_W-1:0] tgt_q [ENTRIES];
    logic [ADDR_W-1:0] tgt_d [ENTRIES];
    logic [CTR_W-1:0]  ctr_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_d [ENTRIES];

    logic [IDX_W-1:0]  l_idx, u_idx;
    logic [TAG_W-1:0]  l_tag, u_tag;
    logic              u_hit;
    logic [CTR_W-1:0]  ctr_nxt;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is never visible.
    assign busy        = (state_q == ST_FLUSH);
    assign hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag) && !busy;
    assign pred_taken  = (PRED_MODE == 0) ? hit : (hit && ctr_q[l_idx][CTR_W-1]);
    assign pred_target = hit ? tgt_q[l_idx] : '0;

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    mips_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
        .ctr_i (ctr_q[u_idx]),
        .inc_i (upd_taken),
        .ctr_o (ctr_nxt)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    ptr_d   = '0;
                end else if (upd_valid) begin
                    if (u_hit) begin
                        ctr_d[u_idx] = ctr_nxt;
                        if (upd_taken) tgt_d[u_idx] = upd_target;
                    end else if (upd_taken) begin
                        valid_d[u_idx] = 1'b1;
                        tag_d[u_idx]   = u_tag;
                        tgt_d[u_idx]   = upd_target;
                        ctr_d[u_idx]   = CTR_WT;
                    end
                end
            end
            ST_FLUSH: begin
                valid_d[ptr_q] = 1'b0;
                ptr_d          = ptr_q + 1'b1;
                if (ptr_q == LAST) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: doc/mips_btb.md
MIPS_BTB -- requirements
Module: mips_btb

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning the number of BTB entries; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the PC and target width.
REQ-003 SHALL have parameter CTR_W, default 2, meaning the width of the saturating counter, at least 1.
REQ-004 SHALL have parameter PRED_MODE, default 1, meaning 0 = predict taken on any hit and 1 = predict from the counter MSB.
REQ-005 SHALL have port clk, input, 1 bit, the single clock (rising edge).
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port lookup_pc, input, ADDR_W bits, the IF-stage fetch PC.
REQ-008 SHALL have port hit, output, 1 bit: lookup_pc matches a valid entry (FindinBTB).
REQ-009 SHALL have port pred_taken, output, 1 bit: the predicted direction.
REQ-010 SHALL have port pred_target, output, ADDR_W bits: the predicted target, 0 when hit=0.
REQ-011 SHALL have port upd_valid, input, 1 bit: a resolved-branch update strobe from EX.
REQ-012 SHALL have port upd_pc, input, ADDR_W bits: the PC of the resolved branch.
REQ-013 SHALL have port upd_taken, input, 1 bit: the actual outcome.
REQ-014 SHALL have port upd_target, input, ADDR_W bits: the actual target.
REQ-015 SHALL have port flush, input, 1 bit: a request to invalidate all entries.
REQ-016 SHALL have port busy, output, 1 bit: a flush walk is in progress.

Function
REQ-017 SHALL derive index = pc[IDX_W+1:2] with IDX_W = log2(ENTRIES), and tag = pc[ADDR_W-1:IDX_W+2].
REQ-018 SHALL have each entry hold a valid bit, a tag, a target and a CTR_W-bit counter.
REQ-019 SHALL compute lookup combinationally from stored state with zero-cycle latency; hit = valid && tag match && !busy.
REQ-020 SHALL set pred_taken = hit when PRED_MODE=0, and hit && ctr[CTR_W-1] when PRED_MODE=1.
REQ-021 SHALL take effect at the clock edge for an update with upd_valid=1, visible to lookups from the next cycle.
REQ-022 SHALL, on update miss with upd_taken=1, allocate or overwrite the entry: valid=1, tag and target written, counter = weakly taken (MSB 1, rest 0).
REQ-023 SHALL, on update miss with upd_taken=0, leave the entry unchanged (no allocation).
REQ-024 SHALL, on update hit, increment the counter saturating at all-ones if taken, otherwise decrement it saturating at zero; the target is written only when taken.
REQ-025 SHALL, when a lookup and an update target the same index in the same cycle, return the pre-update contents (read-old).
REQ-026 SHALL implement an FSM with states IDLE and FLUSH; IDLE goes to FLUSH on flush=1, and walk pointer = 0.
REQ-027 SHALL, in FLUSH, clear one entry's valid bit per cycle at the walk pointer and increment the pointer; FLUSH returns to IDLE after clearing entry ENTRIES-1; busy=1 for exactly ENTRIES cycles.
REQ-028 SHALL ignore updates while busy=1 and ignore flush while in FLUSH (no restart).
REQ-029 SHALL let flush and upd_valid asserted in the same IDLE cycle enter FLUSH, with the update discarded.

Reset
REQ-030 SHALL, on a reset edge, clear all valid bits, set counters and walk pointer to 0, set the FSM to IDLE and set busy=0, all in one cycle.
REQ-031 SHALL, after reset, drive hit=0, pred_taken=0, pred_target=0, busy=0.
REQ-032 SHALL let reset mid-flush abort the walk, with the same result as REQ-030.
REQ-033 SHALL give reset priority over flush and update in the same cycle.

Structure
REQ-034 SHALL place the FSM state encoding, the weakly-taken constant function and the index/tag width helpers in a shared package, mips_pkg.
REQ-035 SHALL use one sub-module, mips_sat_ctr, a combinational CTR_W-bit saturating increment/decrement.
REQ-036 SHALL keep the entry storage in flops (not RAM), so that single-cycle reset clearing is possible.

Verification (ENTRIES=16, CTR_W=2, PRED_MODE=1)
REQ-037 SHALL verify: after reset, lookup_pc=0x40 -> hit=0, pred_taken=0, pred_target=0x0, busy=0.
REQ-038 SHALL verify: update pc=0x40, taken, target 0x100 -> next cycle lookup 0x40 gives hit=1, pred_taken=1, pred_target=0x100.
REQ-039 SHALL verify: three not-taken updates at 0x40 -> counter 10->01->00->00; pred_taken=0 after the first, hit stays 1.
REQ-040 SHALL verify: taken update at 0x80 (same index 0, new tag) -> lookup 0x40 misses, and 0x80 hits with its own target.
REQ-041 SHALL verify: flush pulse with 0x40 valid -> busy=1 for 16 cycles and hit=0 throughout; an update during the walk is ignored; afterwards all lookups miss.
REQ-042 SHALL verify: reset asserted in flush cycle 5 -> busy=0 next cycle and all entries invalid.
